// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the async program ROM and registers the word for decode.
// Optional single-step debug gating is enabled with `define FETCH_STEP_EN (adds the step port).
module instr_fetch #(
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         INSTR_W  = 35,
    parameter logic [INSTR_W-1:0]  NOP_WORD = '0,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               halt,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic step_ok;
    logic load;

`ifdef FETCH_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign load = (state_q == StRun) && !halt && !jump_en && step_ok
                  && (!valid_q || instr_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:   state_d = StRun;
            StRun:    state_d = halt ? StHalted : StRun;
            StHalted: state_d = halt ? StHalted : StRun;
            default:  state_d = StBoot;
        endcase
    end

    // Jump outranks load and consume; it flushes the register and leaves a one-cycle bubble.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        if (jump_en) begin
            pc_d    = jump_addr;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= '0;
            instr_q    <= NOP_WORD;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a cycle-level behavioural model of the fetch rules.
// Build with +define+FETCH_STEP_EN to also exercise the single-step gate.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [34:0] rom_data;
    logic [34:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_pc;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        halt;
    logic        step;
    logic [15:0] fetch_count;

    logic [34:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model state: what the outputs must be, plus edges since reset release and last halt seen.
    logic [7:0]  m_pc;
    logic [34:0] m_instr;
    logic [7:0]  m_ipc;
    logic        m_valid;
    logic [15:0] m_cnt;
    int          m_edges;
    logic        m_halt_prev;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
`ifdef FETCH_STEP_EN
        .step        (step),
`endif
        .fetch_count (fetch_count)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] mov(input int i);
        logic [7:0] a;
        a = i[7:0];
        return {3'b011, 24'h000000, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc        = 8'd0;
        m_instr     = 35'd0;
        m_ipc       = 8'd0;
        m_valid     = 1'b0;
        m_cnt       = 16'd0;
        m_edges     = 0;
        m_halt_prev = 1'b0;
    endtask

    // Advance one clock: derive the model's next outputs from the inputs seen before the edge.
    task automatic tick();
        logic [7:0]  npc;
        logic [34:0] ninstr;
        logic [7:0]  nipc;
        logic        nvalid;
        logic [15:0] ncnt;
        logic        fetching;
        logic        rst_s;
        logic        halt_s;
        npc      = m_pc;
        ninstr   = m_instr;
        nipc     = m_ipc;
        nvalid   = m_valid;
        ncnt     = m_cnt;
        rst_s    = reset;
        halt_s   = halt;
        // Fetching is allowed once boot is over and halt was low at the last edge.
        fetching = (m_edges == 1) || (m_edges >= 2 && !m_halt_prev);
        if (jump_en) begin
            npc    = jump_addr;
            ninstr = 35'd0;
            nvalid = 1'b0;
        end else if (fetching && !halt && step && (!m_valid || instr_ready)) begin
            ninstr = rom[m_pc];
            nipc   = m_pc;
            nvalid = 1'b1;
            npc    = m_pc + 8'd1;
            ncnt   = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        end else if (m_valid && instr_ready) begin
            nvalid = 1'b0;
        end
        @(posedge clk);
        if (rst_s) begin
            model_reset();
        end else begin
            m_pc        = npc;
            m_instr     = ninstr;
            m_ipc       = nipc;
            m_valid     = nvalid;
            m_cnt       = ncnt;
            m_halt_prev = halt_s;
            if (m_edges < 2) m_edges++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rom_addr", rom_addr, m_pc);
            check("instr_valid", instr_valid, m_valid);
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_ipc);
            check("fetch_count", fetch_count, m_cnt);
        end
    end

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", instr_valid, 1'b0);
        check("async_rst_instr", instr, 35'd0);
        check("async_rst_ipc", instr_pc, 8'd0);
        check("async_rst_cnt", fetch_count, 16'd0);
        check("async_rst_addr", rom_addr, 8'd0);
        model_reset();
        tick();
        reset   = 1'b0;
        jump_en = 1'b0;
        halt    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = (i < 10) ? mov(i) : 35'd0;
        reset       = 1'b1;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = 8'd0;
        halt        = 1'b0;
        step        = 1'b1;
        model_reset();
        chk_en = 1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_valid", instr_valid, 1'b0);
        tick();
        check("boot_no_load", instr_valid, 1'b0);
        tick();
        check("first_valid", instr_valid, 1'b1);
        check("first_pc", instr_pc, 8'd0);
        check("first_word", instr, 35'h3_0000_0000);
        for (int i = 1; i < 10; i++) begin
            tick();
            check("stream_pc", instr_pc, i);
        end
        check("count_10", fetch_count, 16'd10);

        jump_en = 1'b1; jump_addr = 8'd2; tick(); jump_en = 1'b0;
        tick(); tick();
        check("pc_3", instr_pc, 8'd3);
        jump_en = 1'b1; jump_addr = 8'd8; tick(); jump_en = 1'b0;
        check("jump_bubble_valid", instr_valid, 1'b0);
        check("jump_bubble_instr", instr, 35'd0);
        tick();
        check("jump_target_pc", instr_pc, 8'd8);
        check("jump_target_word", instr, mov(8));

        jump_en = 1'b1; jump_addr = 8'd4; tick(); jump_en = 1'b0;
        tick();
        check("pc_4", instr_pc, 8'd4);
        instr_ready = 1'b0;
        repeat (3) tick();
        check("stall_pc", instr_pc, 8'd4);
        check("stall_word", instr, mov(4));
        check("stall_addr", rom_addr, 8'd5);
        check("stall_count", fetch_count, 16'd14);
        instr_ready = 1'b1;
        tick();
        check("release_pc", instr_pc, 8'd5);
        check("release_count", fetch_count, 16'd15);

        jump_en = 1'b1; jump_addr = 8'd255; tick(); jump_en = 1'b0;
        tick();
        check("pc_255", instr_pc, 8'd255);
        check("word_255", instr, 35'd0);
        tick();
        check("wrap_pc", instr_pc, 8'd0);
        check("wrap_word", instr, mov(0));

        halt = 1'b1;
        repeat (4) tick();
        check("halt_valid", instr_valid, 1'b0);
        check("halt_frozen", rom_addr, 8'd1);
        halt = 1'b0;
        tick();
        check("unhalt_gap", instr_valid, 1'b0);
        tick();
        check("resume_pc", instr_pc, 8'd1);
        check("resume_valid", instr_valid, 1'b1);

        async_reset();

`ifdef FETCH_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step = (i == 2 || i == 4 || i == 7);
            tick();
        end
        step = 1'b0;
        tick();
        check("step_count", fetch_count, 16'd3);
        check("step_pc", instr_pc, 8'd2);
        step = 1'b1;
`endif

        for (int i = 0; i < 4000; i++) begin
            instr_ready = ($urandom_range(3) != 0);
            jump_en     = ($urandom_range(15) == 0);
            jump_addr   = ($urandom_range(3) == 0) ? 8'(250 + $urandom_range(5))
                                                   : 8'($urandom_range(255));
            if ($urandom_range(19) == 0) halt = ~halt;
`ifdef FETCH_STEP_EN
            step = ($urandom_range(1) == 0);
`endif
            if ($urandom_range(499) == 0) async_reset();
            else tick();
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
